// File: rtl/sram22_fe_pkg.sv
// Shared defaults, response entry layout and count-width helper for the sram22 request frontend.
package sram22_fe_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 9;
  localparam int DEF_WMASK_WIDTH = 1;
  localparam int DEF_RESP_DEPTH  = 2;

  typedef struct packed {
    logic                      wack;
    logic [DEF_DATA_WIDTH-1:0] rdata;
  } resp_entry_t;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram22_fe_resp_fifo.sv
// Synchronous response FIFO with combinational head; async active-high reset.
module sram22_fe_resp_fifo
  import sram22_fe_pkg::*;
#(
  parameter int W     = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_RESP_DEPTH,
  localparam int CW   = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assert property (@(posedge clk) disable iff (rst) !(push && full));
  assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/sram22_rv_frontend.sv
// Valid/ready request stage in front of one sram22 single-port macro; read data lands in a credit-protected FIFO.
// Optional SRAM_FE_WRITE_ACK_EN adds resp_wack and makes writes push an ordered acknowledge entry.
module sram22_rv_frontend
  import sram22_fe_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WMASK_WIDTH = DEF_WMASK_WIDTH,
  parameter int RESP_DEPTH  = DEF_RESP_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_WIDTH-1:0]  resp_rdata,
`ifdef SRAM_FE_WRITE_ACK_EN
  output logic                   resp_wack,
`endif
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int CW = count_width(RESP_DEPTH);
`ifdef SRAM_FE_WRITE_ACK_EN
  localparam int EW = DATA_WIDTH + 1;
`else
  localparam int EW = DATA_WIDTH;
`endif

  // Handshakes: a transfer happens on a clk edge where valid && ready; valid never waits on ready.
  logic          accept;
  logic          launch;
  logic          pop;
  logic          push;
  logic          rd_inflight;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic [EW-1:0] push_data;
  logic [EW-1:0] head;

  assign pop       = resp_valid && resp_ready;
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(rd_inflight) - (CW+1)'(pop);
  assign req_ready = !rst && (occupancy < (CW+1)'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;

  assign sram_we    = accept && req_we;
  assign sram_wmask = sram_we ? req_wmask : '0;
  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;

  assign push = rd_inflight;

`ifdef SRAM_FE_WRITE_ACK_EN
  logic inflight_wack;

  assign launch    = accept;
  assign push_data = {inflight_wack, inflight_wack ? {DATA_WIDTH{1'b0}} : sram_dout};
  assign resp_wack = !fifo_empty && head[DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_wack <= 1'b0;
    else     inflight_wack <= req_we;
  end
`else
  assign launch    = accept && !req_we;
  assign push_data = sram_dout;
`endif

  // Set by the launching edge; sram_dout is valid for exactly the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_inflight <= 1'b0;
    else     rd_inflight <= launch;
  end

  sram22_fe_resp_fifo #(
    .W     (EW),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign resp_valid = !fifo_empty;
  assign resp_rdata = fifo_empty ? '0 : head[DATA_WIDTH-1:0];

  assert property (@(posedge clk) disable iff (rst) !(fifo_full && rd_inflight));

endmodule

// File: tb/tb_sram22_rv_frontend.sv
// Bench for sram22_rv_frontend with a behavioural 512x32 single-port macro model behind it.
module tb_sram22_rv_frontend;
  import sram22_fe_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int MW    = 1;
  localparam int SW    = DW / MW;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [MW-1:0] req_wmask;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_wack_s;
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  sram22_rv_frontend #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .WMASK_WIDTH (MW),
    .RESP_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
`ifdef SRAM_FE_WRITE_ACK_EN
    .resp_wack  (resp_wack_s),
`endif
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

`ifndef SRAM_FE_WRITE_ACK_EN
  assign resp_wack_s = 1'b0;
`endif

  // Macro model: registered address/data, one-cycle read, dout undefined after a write.
  logic [DW-1:0] mac_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_we) begin
      for (int s = 0; s < MW; s++)
        if (sram_wmask[s]) mac_mem[sram_addr][s*SW +: SW] <= sram_din[s*SW +: SW];
      sram_dout <= 'x;
    end else begin
      sram_dout <= mac_mem[sram_addr];
    end
  end

  // Clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int            checks   = 0;
  int            failures = 0;
  int            n_resp   = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic          acc;
  logic          popd;
  logic          last_rv;
  logic          use_tbl  = 1'b0;
  logic [DW-1:0] tbl_exp  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [MW-1:0] m,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_wmask = m;
    req_addr  = a;
    req_wdata = d;
  endtask

  // One cycle: sample at negedge, score, then advance to just after the next posedge.
  task automatic tick();
    logic [DW:0] e;
    int          occ;
    @(negedge clk);
    acc     = req_valid && req_ready;
    popd    = resp_valid && resp_ready;
    last_rv = resp_valid;
    if (!rst) begin
      occ = exp_q.size() - (popd ? 1 : 0);
      chk("credit_ready", {63'd0, req_ready}, {63'd0, occ < DEPTH});
      if (exp_q.size() == 0) chk("resp_valid_idle", {63'd0, resp_valid}, 64'd0);
    end
    if (popd) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got %0h expected none", resp_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("resp_entry", {31'd0, resp_wack_s, resp_rdata}, {31'd0, e});
      end
    end
    if (acc) begin
      if (req_we) begin
        for (int s = 0; s < MW; s++)
          if (req_wmask[s]) ref_mem[req_addr][s*SW +: SW] = req_wdata[s*SW +: SW];
`ifdef SRAM_FE_WRITE_ACK_EN
        exp_q.push_back({1'b1, {DW{1'b0}}});
`endif
      end else begin
        exp_q.push_back({1'b0, use_tbl ? tbl_exp : ref_mem[req_addr]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [MW-1:0] m,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    drive(1'b1, we, m, a, d);
    do begin
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic drain();
    int n = 0;
    resp_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    while ((exp_q.size() != 0 || resp_valid) && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk("drain_empty", {32'd0, exp_q.size()}, 64'd0);
  endtask

  typedef struct {
    logic          we;
    logic [MW-1:0] mask;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];
  int   base;
  logic pend;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 9'h005, 32'h00000001, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 9'h005, 32'h0,        32'h00000001};
    vecs[4] = '{1'b1, 1'b0, 9'h005, 32'hFFFFFFFF, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 9'h005, 32'h0,        32'h00000001};
    vecs[6] = '{1'b1, 1'b1, 9'h1FF, 32'hA5A5A5A5, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 9'h1FF, 32'h0,        32'hA5A5A5A5};
    vecs[8] = '{1'b0, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF};

    rst        = 1'b1;
    resp_ready = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    #2;
    chk("reset_req_ready",  {63'd0, req_ready},  64'd0);
    chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("reset_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    drive(1'b1, 1'b1, 1'b1, 9'h003, 32'h12345678);
    #1;
    chk("reset_sram_we",    {63'd0, sram_we},    64'd0);
    chk("reset_sram_wmask", {63'd0, sram_wmask}, 64'd0);
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table: back-to-back write/read pairs at full rate, including masked-off write.
    resp_ready = 1'b1;
    use_tbl    = 1'b1;
    foreach (vecs[i]) begin
      tbl_exp = vecs[i].exp_rdata;
      drive(1'b1, vecs[i].we, vecs[i].mask, vecs[i].addr, vecs[i].wdata);
      tick();
      chk("tbl_accept", {63'd0, acc}, 64'd1);
    end
    use_tbl = 1'b0;
    drain();

    // Single read latency: no response after edge N, response after edge N+1.
    drive(1'b1, 1'b0, '0, 9'h010, '0);
    tick();
    chk("lat_accept", {63'd0, acc}, 64'd1);
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("lat_edge_n", {63'd0, last_rv}, 64'd0);
    tick();
    chk("lat_edge_n1", {63'd0, last_rv}, 64'd1);
    drain();

    // Preload addr*3, then 16 back-to-back reads.
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 1'b1, 1'b1, AW'(a), DW'(a * 3));
      tick();
    end
    base = n_resp;
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 1'b0, '0, AW'(a), '0);
      tick();
      chk("b2b_ready", {63'd0, acc}, 64'd1);
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();
    chk("b2b_resp_count", {32'd0, n_resp - base}, 64'd16);
    drain();

    // Backpressure: third read waits for the first pop.
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, '0, 9'h001, '0);
    tick();
    chk("bp_first", {63'd0, acc}, 64'd1);
    drive(1'b1, 1'b0, '0, 9'h002, '0);
    tick();
    chk("bp_second", {63'd0, acc}, 64'd1);
    drive(1'b1, 1'b0, '0, 9'h003, '0);
    tick();
    chk("bp_third_blocked", {63'd0, acc}, 64'd0);
    tick();
    chk("bp_third_held", {63'd0, acc}, 64'd0);
    resp_ready = 1'b1;
    tick();
    chk("bp_third_with_pop", {62'd0, acc, popd}, 64'd3);
    drain();

    // Reset with one entry queued and one read in flight.
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, '0, 9'h004, '0);
    tick();
    drive(1'b1, 1'b0, '0, 9'h005, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_req_ready",  {63'd0, req_ready},  64'd0);
    chk("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    tick();
    tick();
    chk("rst_no_stale", {63'd0, last_rv}, 64'd0);
    base = n_resp;
    send(1'b0, '0, 9'h006, '0);
    drain();
    chk("rst_new_read", {32'd0, n_resp - base}, 64'd1);

`ifdef SRAM_FE_WRITE_ACK_EN
    // Write, read, write produce three in-order entries.
    base = n_resp;
    drive(1'b1, 1'b1, 1'b1, 9'h020, 32'hCAFEF00D);
    tick();
    drive(1'b1, 1'b0, '0, 9'h020, '0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 9'h021, 32'h0BADBEEF);
    tick();
    drain();
    chk("wack_resp_count", {32'd0, n_resp - base}, 64'd3);
`endif

    // Randomized traffic over a preloaded window.
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 1'b1, 1'b1, AW'(a), $urandom);
      tick();
    end
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pend) begin
        if ($urandom_range(0, 3) != 0) begin
          drive(1'b1, 1'($urandom_range(0, 1)), MW'($urandom_range(0, 1)),
                AW'($urandom_range(0, 31)), $urandom);
          pend = 1'b1;
        end else begin
          drive(1'b0, 1'b0, '0, '0, '0);
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc) pend = 1'b0;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
